// File: rtl/bip_pkg.sv
// Shared encodings for the accumulator processor: opcodes, control FSM states
// and the datapath mux/ALU select values used by both control and datapath.
package bip_pkg;

  localparam int OPCODE_W = 5;

  localparam logic [OPCODE_W-1:0] OP_HALT  = 5'b00000;
  localparam logic [OPCODE_W-1:0] OP_STORE = 5'b00001;
  localparam logic [OPCODE_W-1:0] OP_LDV   = 5'b00010;
  localparam logic [OPCODE_W-1:0] OP_LDI   = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_ADDV  = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 5'b00101;
  localparam logic [OPCODE_W-1:0] OP_SUBV  = 5'b00110;
  localparam logic [OPCODE_W-1:0] OP_SUBI  = 5'b00111;

  localparam logic [1:0] SEL_A_MEM = 2'd0;
  localparam logic [1:0] SEL_A_IMM = 2'd1;
  localparam logic [1:0] SEL_A_ALU = 2'd2;

  localparam logic SEL_B_MEM = 1'b0;
  localparam logic SEL_B_IMM = 1'b1;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEMWB  = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

endpackage

// File: rtl/bip_instr_decoder.sv
// Combinational opcode decoder: instruction class flags plus the datapath
// selects to apply in the cycle that writes the accumulator.
module bip_instr_decoder
  import bip_pkg::*;
(
  input  logic [OPCODE_W-1:0] i_opcode,
  output logic                o_is_halt,
  output logic                o_is_store,
  output logic                o_is_mem_read,
  output logic                o_is_illegal,
  output logic [1:0]          o_sel_a,
  output logic                o_sel_b,
  output logic                o_op
);

  always_comb begin
    o_is_halt     = 1'b0;
    o_is_store    = 1'b0;
    o_is_mem_read = 1'b0;
    o_is_illegal  = 1'b0;
    o_sel_a       = SEL_A_MEM;
    o_sel_b       = SEL_B_MEM;
    o_op          = ALU_ADD;
    unique case (i_opcode)
      OP_HALT:  o_is_halt  = 1'b1;
      OP_STORE: o_is_store = 1'b1;
      OP_LDV:   o_is_mem_read = 1'b1;
      OP_LDI:   o_sel_a = SEL_A_IMM;
      OP_ADDV: begin
        o_is_mem_read = 1'b1;
        o_sel_a       = SEL_A_ALU;
      end
      OP_ADDI: begin
        o_sel_a = SEL_A_ALU;
        o_sel_b = SEL_B_IMM;
      end
      OP_SUBV: begin
        o_is_mem_read = 1'b1;
        o_sel_a       = SEL_A_ALU;
        o_op          = ALU_SUB;
      end
      OP_SUBI: begin
        o_sel_a = SEL_A_ALU;
        o_sel_b = SEL_B_IMM;
        o_op    = ALU_SUB;
      end
      default:  o_is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/bip_control_unit.sv
// Fetch/decode/sequence controller for the accumulator processor: owns the
// PC, instruction register and retired-instruction counter.
module bip_control_unit
  import bip_pkg::*;
#(
  parameter int NBITS_O  = 11,
  parameter int NBITS_D  = 16,
  parameter int NBITS_OP = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  output logic [NBITS_O-1:0] o_pc_addr,
  input  logic [NBITS_D-1:0] i_instr,
  output logic [NBITS_O-1:0] o_operand,
  output logic [1:0]         o_sel_a,
  output logic               o_sel_b,
  output logic               o_op,
  output logic               o_wr_acc,
  output logic               o_wr_ram,
  output logic               o_rd_ram,
  output logic               o_halted,
  output logic               o_illegal,
  output logic [15:0]        o_instr_count
);

  state_t               state_q, state_d;
  logic [NBITS_O-1:0]   pc_q, pc_d;
  logic [NBITS_D-1:0]   ir_q, ir_d;
  logic [15:0]          count_q, count_d;
  logic                 illegal_q, illegal_d;
  logic                 pc_inc;

  logic                 dec_halt, dec_store, dec_mem_read, dec_illegal;
  logic [1:0]           dec_sel_a;
  logic                 dec_sel_b, dec_op;

  bip_instr_decoder u_decoder (
    .i_opcode      (ir_q[NBITS_D-1 -: NBITS_OP]),
    .o_is_halt     (dec_halt),
    .o_is_store    (dec_store),
    .o_is_mem_read (dec_mem_read),
    .o_is_illegal  (dec_illegal),
    .o_sel_a       (dec_sel_a),
    .o_sel_b       (dec_sel_b),
    .o_op          (dec_op)
  );

  // Everything holds while disabled, so a paused state simply resumes later.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    pc_inc    = 1'b0;
    if (i_enable) begin
      unique case (state_q)
        ST_FETCH:  state_d = ST_DECODE;
        ST_DECODE: begin
          ir_d    = i_instr;
          state_d = ST_EXEC;
        end
        ST_EXEC: begin
          if (dec_halt) begin
            state_d = ST_HALT;
          end else if (dec_mem_read) begin
            state_d = ST_MEMWB;
          end else begin
            illegal_d = illegal_q | dec_illegal;
            pc_inc    = 1'b1;
            state_d   = ST_FETCH;
          end
        end
        ST_MEMWB: begin
          pc_inc  = 1'b1;
          state_d = ST_FETCH;
        end
        ST_HALT:  state_d = ST_HALT;
        default:  state_d = ST_FETCH;
      endcase
    end
    pc_d    = pc_inc ? pc_q + NBITS_O'(1) : pc_q;
    count_d = (pc_inc && count_q != COUNT_MAX) ? count_q + 16'd1 : count_q;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= ST_FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  // Immediate ops write the accumulator in EXEC; memory ops do it in MEMWB.
  always_comb begin
    o_wr_acc = 1'b0;
    o_wr_ram = 1'b0;
    o_rd_ram = 1'b0;
    o_sel_a  = SEL_A_MEM;
    o_sel_b  = SEL_B_MEM;
    o_op     = ALU_ADD;
    if (i_enable) begin
      if (state_q == ST_EXEC) begin
        if (dec_store) begin
          o_wr_ram = 1'b1;
        end else if (dec_mem_read) begin
          o_rd_ram = 1'b1;
        end else if (!dec_halt && !dec_illegal) begin
          o_wr_acc = 1'b1;
          o_sel_a  = dec_sel_a;
          o_sel_b  = dec_sel_b;
          o_op     = dec_op;
        end
      end else if (state_q == ST_MEMWB) begin
        o_wr_acc = 1'b1;
        o_sel_a  = dec_sel_a;
        o_sel_b  = dec_sel_b;
        o_op     = dec_op;
      end
    end
  end

  assign o_pc_addr     = pc_q;
  assign o_operand     = ir_q[NBITS_O-1:0];
  assign o_halted      = (state_q == ST_HALT);
  assign o_illegal     = illegal_q;
  assign o_instr_count = count_q;

endmodule
